xor_unit_arbiter: RTL
=====================

Name: xor_unit_arbiter

Overview:
- Shares one combinational WIDTH-bit bitwise XOR datapath between NREQ requesters.
- Arbitration is round-robin. Each requester uses a valid/ready handshake.
- The winner's result is registered and presented on a single response channel. The channel carries the requester ID, an equality flag and a completed-operation counter.
- Sits between the ALU-side compare/flag logic and the units that need XOR results, such as the branch-equality check and the checksum helper.

Parameters:
- WIDTH, 32, operand and result width.
- NREQ, 4, number of requesters; must be 2..8.
- IDW, $clog2(NREQ), width of requester ID.
- CNTW, 16, width of the completed-operation counter.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high.
- req_valid  input  NREQ  per-requester request valid.
- req_a  input  NREQ*WIDTH  operand A; requester i occupies bits [i*WIDTH +: WIDTH].
- req_b  input  NREQ*WIDTH  operand B; same packing as req_a.
- req_ready  output  NREQ  one-hot grant/accept; combinational.
- rsp_valid  output  1  registered result valid.
- rsp_data  output  WIDTH  registered a^b of the accepted request.
- rsp_id  output  IDW  index of the requester that owns rsp_data.
- rsp_zero  output  1  high when rsp_data == 0, i.e. a == b.
- rsp_ready  input  1  consumer accepts the response.
- op_count  output  CNTW  number of responses consumed; saturates at all-ones.

Behaviour:
- Reset values, applied on the edge where reset is sampled high:
  - rsp_valid=0, rsp_data=0, rsp_id=0, rsp_zero=0, op_count=0.
  - state=IDLE.
  - last_grant=NREQ-1, so requester 0 has first priority after reset.
- req_ready is forced to 0 while reset is high.
- States:
  - IDLE: no result held.
  - HOLD: result held, rsp_valid=1.
- accept_ok = (state==IDLE) | (state==HOLD & rsp_ready).
- Grant selection:
  - g is the first i with req_valid[i]=1, scanning from last_grant+1 upward and wrapping modulo NREQ.
  - req_ready[g]=1 only when accept_ok and some req_valid is high; all other req_ready bits are 0.
  - req_ready never asserts for a requester whose req_valid is low.
- Acceptance happens when req_valid[g] & req_ready[g]. On the next edge:
  - rsp_data <= a_g ^ b_g and rsp_id <= g.
  - rsp_zero <= (a_g ^ b_g == 0).
  - rsp_valid <= 1, last_grant <= g, state <= HOLD.
- Latency: exactly 1 cycle from acceptance edge to rsp_valid.
- Response consumed (rsp_valid & rsp_ready) with no new acceptance in the same cycle:
  - rsp_valid <= 0 and state <= IDLE.
  - rsp_data, rsp_id and rsp_zero hold their last values.
- Simultaneous consume and accept in HOLD: the new result replaces the old one and rsp_valid stays 1. Sustained throughput is 1 op/cycle.
- HOLD without rsp_ready: all response outputs are stable and req_ready is all zero (backpressure).
- op_count:
  - Increments by 1 on each consumed response (rsp_valid & rsp_ready).
  - Holds at 2^CNTW-1 once reached; no wrap.
- Requester obligations: once req_valid is raised, the requester holds req_valid, a and b stable until its req_ready is seen high.
- The block does not check requester obligations. A requester dropping valid early simply loses arbitration.
- Fairness: a requester that holds req_valid continuously is granted within NREQ acceptances.
- Reset mid-operation: any held result is discarded with no response handshake, and the counter clears.
- The combinational path from req_valid to req_ready must not depend on rsp_data, so there is no loop with the datapath.

Decomposition:
- Package xor_arb_pkg:
  - typedef enum logic {IDLE, HOLD} state_t.
  - Localparam DEFAULT_WIDTH=32.
  - Function rr_next(last, valid) returning the next grant index.
- Sub-module rr_picker (NREQ): inputs valid and last_grant; outputs grant_onehot, grant_idx and any_valid. Purely combinational.
- XOR datapath: instantiate the team's existing generate-loop bitwise XOR module (thirtyTwoBitXor) with WIDTH, fed by an NREQ:1 operand mux driven by grant_idx.

Test Plan:
- Reset then single request: req_valid=4'b0001, a=32'h0000_00FF, b=32'h0000_000F -> req_ready=4'b0001 in the same cycle; next cycle rsp_valid=1, rsp_data=32'h0000_00F0, rsp_id=0, rsp_zero=0; with rsp_ready=1, op_count=1 on the following edge.
- Equal operands: a=b=32'hDEAD_BEEF on requester 2 -> rsp_data=0, rsp_zero=1, rsp_id=2.
- Round-robin: all four req_valid held high, rsp_ready=1 constantly -> grant order 0,1,2,3,0 on consecutive cycles; rsp_valid stays 1 with no bubbles; op_count reaches 5 after five consumes.
- Backpressure: rsp_ready=0 for 3 cycles while requesters 1 and 3 are valid -> req_ready=0, rsp_data/rsp_id stable for all 3 cycles; on release, requester 1 is granted first when last_grant=0, then 3.
- Reset mid-HOLD: hold a result with rsp_ready=0, assert reset for 1 cycle -> rsp_valid=0, op_count=0, and the next grant goes to requester 0 even if requester 3 is also valid.
- Counter saturation with CNTW=4: 20 consumed ops -> op_count stops at 4'hF.

Source files
------------

// File: rtl/xor_arb_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : xor_arb_pkg
//  Description : Shared types, constants and the round-robin search helper
//                used by the XOR unit arbiter.
//  Revision    : 1.0 - initial release
// ============================================================================
package xor_arb_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_t;

    localparam int DEFAULT_WIDTH = 32;

    // Largest requester count the helper supports; indices fit in 3 bits.
    localparam int MAX_NREQ = 8;

    // Next grant index: first valid requester scanning upward from last+1,
    // wrapping modulo nreq. Returns last when nothing is valid (callers gate
    // on any_valid). The scan runs downward so the nearest hit wins last.
    function automatic logic [2:0] rr_next(input logic [2:0] last,
                                           input logic [7:0] valid,
                                           input int         nreq);
        logic [2:0] idx;
        int         cand;
        idx = last;
        for (int k = MAX_NREQ; k >= 1; k--) begin
            if (k <= nreq) begin
                cand = (int'(last) + k) % nreq;
                if (valid[cand[2:0]]) begin
                    idx = cand[2:0];
                end
            end
        end
        return idx;
    endfunction

endpackage
`default_nettype wire

// File: rtl/rr_picker.sv
`default_nettype none
// ============================================================================
//  Module      : rr_picker
//  Description : Combinational round-robin selector. Picks the first valid
//                requester after last_grant and reports it one-hot and
//                as an index.
//  Revision    : 1.0 - initial release
// ============================================================================
module rr_picker
    import xor_arb_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int IDW  = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] valid,
    input  logic [IDW-1:0]  last_grant,
    output logic [NREQ-1:0] grant_onehot,
    output logic [IDW-1:0]  grant_idx,
    output logic            any_valid
);

    logic [7:0] w_valid8;
    logic [2:0] w_last3;
    logic [2:0] w_next3;

    assign w_valid8  = 8'(valid);
    assign w_last3   = 3'(last_grant);
    assign w_next3   = rr_next(w_last3, w_valid8, NREQ);
    assign grant_idx = IDW'(w_next3);
    assign any_valid = |valid;

    // One-hot form of the chosen index, empty when nobody is requesting.
    genvar i;
    generate
        for (i = 0; i < NREQ; i++) begin : g_onehot
            assign grant_onehot[i] = any_valid && (grant_idx == IDW'(i));
        end
    endgenerate

endmodule
`default_nettype wire

// File: rtl/thirtyTwoBitXor.sv
`default_nettype none
// ============================================================================
//  Module      : thirtyTwoBitXor
//  Description : Bitwise XOR of two WIDTH-bit operands built from a
//                per-bit generate loop.
//  Revision    : 1.0 - initial release
// ============================================================================
module thirtyTwoBitXor #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] result
);

    genvar i;
    generate
        for (i = 0; i < WIDTH; i++) begin : g_bit
            assign result[i] = a[i] ^ b[i];
        end
    endgenerate

endmodule
`default_nettype wire

// File: rtl/xor_unit_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : xor_unit_arbiter
//  Description : Round-robin shares one XOR datapath among NREQ requesters
//                and returns a registered result with id, zero flag and a
//                saturating completed-operation count.
//  Revision    : 1.0 - initial release
// ============================================================================
module xor_unit_arbiter
    import xor_arb_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int NREQ  = 4,
    parameter int IDW   = $clog2(NREQ),
    parameter int CNTW  = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NREQ-1:0]       req_valid,
    input  logic [NREQ*WIDTH-1:0] req_a,
    input  logic [NREQ*WIDTH-1:0] req_b,
    output logic [NREQ-1:0]       req_ready,
    output logic                  rsp_valid,
    output logic [WIDTH-1:0]      rsp_data,
    output logic [IDW-1:0]        rsp_id,
    output logic                  rsp_zero,
    input  logic                  rsp_ready,
    output logic [CNTW-1:0]       op_count
);

    state_t           r_state;
    state_t           w_state_next;
    logic [IDW-1:0]   r_last_grant;
    logic [WIDTH-1:0] r_rsp_data;
    logic [IDW-1:0]   r_rsp_id;
    logic             r_rsp_zero;
    logic [CNTW-1:0]  r_op_count;

    logic [NREQ-1:0]  w_grant_onehot;
    logic [IDW-1:0]   w_grant_idx;
    logic             w_any_valid;
    logic             w_accept_ok;
    logic             w_accept;
    logic             w_consume;
    logic [WIDTH-1:0] w_a;
    logic [WIDTH-1:0] w_b;
    logic [WIDTH-1:0] w_xor;

    rr_picker #(
        .NREQ (NREQ),
        .IDW  (IDW)
    ) u_picker (
        .valid        (req_valid),
        .last_grant   (r_last_grant),
        .grant_onehot (w_grant_onehot),
        .grant_idx    (w_grant_idx),
        .any_valid    (w_any_valid)
    );

    // Grant path depends only on valid, state and rsp_ready, never on data.
    assign w_accept_ok = (r_state == IDLE) || ((r_state == HOLD) && rsp_ready);
    assign req_ready   = (!reset && w_accept_ok && w_any_valid) ? w_grant_onehot : '0;
    assign w_accept    = |req_ready;
    assign w_consume   = rsp_valid && rsp_ready;

    // Operand mux steering the winning requester into the shared XOR.
    always_comb begin
        w_a = '0;
        w_b = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (w_grant_idx == IDW'(i)) begin
                w_a = req_a[i*WIDTH +: WIDTH];
                w_b = req_b[i*WIDTH +: WIDTH];
            end
        end
    end

    thirtyTwoBitXor #(
        .WIDTH (WIDTH)
    ) u_xor (
        .a      (w_a),
        .b      (w_b),
        .result (w_xor)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next state: a new acceptance always lands in HOLD; a bare consume empties.
    always_comb begin
        w_state_next = r_state;
        if (w_accept) begin
            w_state_next = HOLD;
        end else if (w_consume) begin
            w_state_next = IDLE;
        end
    end

    // Response payload and arbitration pointer, loaded on acceptance only.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_rsp_data   <= '0;
            r_rsp_id     <= '0;
            r_rsp_zero   <= 1'b0;
            r_last_grant <= IDW'(NREQ - 1);
        end else if (w_accept) begin
            r_rsp_data   <= w_xor;
            r_rsp_id     <= w_grant_idx;
            r_rsp_zero   <= (w_xor == '0);
            r_last_grant <= w_grant_idx;
        end
    end

    // Completed-operation counter, sticks at all-ones.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_op_count <= '0;
        end else if (w_consume && (r_op_count != '1)) begin
            r_op_count <= r_op_count + 1'b1;
        end
    end

    assign rsp_valid = (r_state == HOLD);
    assign rsp_data  = r_rsp_data;
    assign rsp_id    = r_rsp_id;
    assign rsp_zero  = r_rsp_zero;
    assign op_count  = r_op_count;

endmodule
`default_nettype wire
